// File: rtl/mesi.sv
// Per-line MESI coherence controller: maps a processor request or snooped bus message to next state, bus message and memory message.
// Latency: one cycle; all outputs are registered from inputs sampled at the rising edge.
// Backpressure: none; the block recomputes every cycle with no enable and no internal sequencing.
module mesi (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] op,
  input  logic [1:0] bus_msg_in,
  input  logic [1:0] cur_state,
  output logic [1:0] bus_msg_out,
  output logic [1:0] mem_msg_out,
  output logic [1:0] next_state
);

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_E = 2'b10,
    ST_M = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_RDMISS = 2'b01,
    BUS_WRMISS = 2'b10,
    BUS_INVAL = 2'b11
  } bus_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_FLUSH = 2'b01,
    MEM_WBACK = 2'b10
  } mem_e;

  logic       mode;
  logic [1:0] action;
  logic       shared;
  state_e     cur;

  state_e     next_state_d, next_state_q;
  bus_e       bus_msg_d,    bus_msg_q;
  mem_e       mem_msg_d,    mem_msg_q;

  assign mode   = op[3];
  assign action = op[2:1];
  assign shared = op[0];
  assign cur    = state_e'(cur_state);

  // Decode the transition table for the current request or snooped message.
  always_comb begin
    next_state_d = cur;
    bus_msg_d    = BUS_NONE;
    mem_msg_d    = MEM_NONE;

    if (mode) begin
      // Processor request; the snooped bus message is irrelevant here.
      unique case (action)
        2'b00: begin  // read miss: evict a dirty victim before refilling
          next_state_d = shared ? ST_S : ST_E;
          bus_msg_d    = BUS_RDMISS;
          mem_msg_d    = (cur == ST_M) ? MEM_WBACK : MEM_NONE;
        end
        2'b01: begin  // read hit: line keeps its state; a hit on I stays I
          next_state_d = cur;
        end
        2'b10: begin  // write miss
          next_state_d = ST_M;
          bus_msg_d    = BUS_WRMISS;
          mem_msg_d    = (cur == ST_M) ? MEM_WBACK : MEM_NONE;
        end
        default: begin  // write hit
          next_state_d = ST_M;
          unique case (cur)
            ST_S:    bus_msg_d = BUS_INVAL;   // other copies must be dropped
            ST_I:    bus_msg_d = BUS_WRMISS;  // not really a hit, treat as miss
            default: bus_msg_d = BUS_NONE;    // E/M already own the line
          endcase
        end
      endcase
    end else begin
      // Snoop: respond to another cache's bus traffic; never broadcast.
      unique case (bus_e'(bus_msg_in))
        BUS_NONE: begin
          next_state_d = cur;
        end
        BUS_RDMISS: begin  // remote reader: any valid copy supplies data, drops to S
          next_state_d = (cur == ST_I) ? ST_I : ST_S;
          mem_msg_d    = (cur == ST_I) ? MEM_NONE : MEM_FLUSH;
        end
        BUS_WRMISS: begin  // remote writer: only a dirty copy must supply data
          next_state_d = ST_I;
          mem_msg_d    = (cur == ST_M) ? MEM_FLUSH : MEM_NONE;
        end
        default: begin     // invalidate
          next_state_d = ST_I;
        end
      endcase
    end
  end

  // Register the outputs; clear wins over any request in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      next_state_q <= ST_I;
      bus_msg_q    <= BUS_NONE;
      mem_msg_q    <= MEM_NONE;
    end else begin
      next_state_q <= next_state_d;
      bus_msg_q    <= bus_msg_d;
      mem_msg_q    <= mem_msg_d;
    end
  end

  assign next_state  = next_state_q;
  assign bus_msg_out = bus_msg_q;
  assign mem_msg_out = mem_msg_q;

endmodule

// File: tb/tb_mesi.sv
// Randomized and directed bench for the MESI line controller against a behavioural table model.
// Latency: expects every output one edge after its inputs were applied.
// Backpressure: none.
module tb_mesi;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] op;
  logic [1:0] bus_msg_in;
  logic [1:0] cur_state;
  logic [1:0] bus_msg_out;
  logic [1:0] mem_msg_out;
  logic [1:0] next_state;

  int total = 0;
  int bad   = 0;

  mesi dut (
    .clock       (clock),
    .clear       (clear),
    .op          (op),
    .bus_msg_in  (bus_msg_in),
    .cur_state   (cur_state),
    .bus_msg_out (bus_msg_out),
    .mem_msg_out (mem_msg_out),
    .next_state  (next_state)
  );

  always #5 clock = ~clock;

  // Compare {next, bus, mem} against the expected triple.
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got next=%b bus=%b mem=%b, expected next=%b bus=%b mem=%b",
               tag, got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // Reference: coherence rules written as named-state decisions, returns {next, bus, mem}.
  function automatic logic [5:0] model(input logic [3:0] o, input logic [1:0] bin, input logic [1:0] cur);
    logic [1:0] nx, bo, mo;
    bit is_i, is_s, is_e, is_m;
    bit rd_miss, rd_hit, wr_miss, wr_hit;
    is_i = (cur == 2'd0); is_s = (cur == 2'd1); is_e = (cur == 2'd2); is_m = (cur == 2'd3);
    rd_miss = (o[2:1] == 2'd0); rd_hit = (o[2:1] == 2'd1);
    wr_miss = (o[2:1] == 2'd2); wr_hit = (o[2:1] == 2'd3);
    nx = cur; bo = 2'd0; mo = 2'd0;
    if (o[3]) begin
      if (wr_hit && is_i) begin wr_hit = 0; wr_miss = 1; end
      if (rd_miss) begin
        nx = o[0] ? 2'd1 : 2'd2;
        bo = 2'd1;
        mo = is_m ? 2'd2 : 2'd0;
      end else if (rd_hit) begin
        nx = cur;
      end else if (wr_miss) begin
        nx = 2'd3; bo = 2'd2;
        mo = is_m ? 2'd2 : 2'd0;
      end else begin
        nx = 2'd3;
        bo = is_s ? 2'd3 : 2'd0;
      end
    end else begin
      case (bin)
        2'd0: nx = cur;
        2'd1: begin nx = is_i ? 2'd0 : 2'd1; mo = is_i ? 2'd0 : 2'd1; end
        2'd2: begin nx = 2'd0; mo = is_m ? 2'd1 : 2'd0; end
        default: nx = 2'd0;
      endcase
    end
    return {nx, bo, mo};
  endfunction

  // Apply inputs at the falling edge, then check one edge later.
  task automatic step(input string tag, input logic clr, input logic [3:0] o,
                      input logic [1:0] bin, input logic [1:0] cur);
    logic [5:0] exp;
    @(negedge clock);
    clear = clr; op = o; bus_msg_in = bin; cur_state = cur;
    exp = clr ? 6'd0 : model(o, bin, cur);
    @(posedge clock);
    #1;
    chk(tag, {next_state, bus_msg_out, mem_msg_out}, exp);
  endtask

  initial begin
    clear = 1'b1; op = 4'b1101; bus_msg_in = 2'b10; cur_state = 2'b11;

    // Reset with arbitrary inputs.
    step("reset0", 1'b1, 4'b1101, 2'b01, 2'b11);
    step("reset1", 1'b1, 4'b0011, 2'b10, 2'b01);
    chk("reset_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_00);

    // Directed cases, with absolute expectations alongside the model.
    step("rdmiss_sh", 1'b0, 4'b1001, 2'b00, 2'b00);
    chk("rdmiss_sh_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b01_01_00);
    step("rdmiss_m", 1'b0, 4'b1000, 2'b11, 2'b11);
    chk("rdmiss_m_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b10_01_10);
    step("wrhit_s", 1'b0, 4'b1110, 2'b00, 2'b01);
    chk("wrhit_s_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b11_11_00);
    step("wrhit_e", 1'b0, 4'b1111, 2'b01, 2'b10);
    chk("wrhit_e_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b11_00_00);
    step("wrhit_i", 1'b0, 4'b1110, 2'b00, 2'b00);
    chk("wrhit_i_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b11_10_00);
    step("wrmiss_i", 1'b0, 4'b1100, 2'b00, 2'b00);
    chk("wrmiss_i_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b11_10_00);
    step("wrmiss_m", 1'b0, 4'b1101, 2'b00, 2'b11);
    chk("wrmiss_m_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b11_10_10);
    for (int c = 3; c >= 0; c--) begin
      step("rdhit", 1'b0, 4'b1010, 2'b11, c[1:0]);
      chk("rdhit_abs", {next_state, bus_msg_out, mem_msg_out}, {c[1:0], 4'b0000});
    end
    step("snp_rd_m", 1'b0, 4'b0111, 2'b01, 2'b11);
    chk("snp_rd_m_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b01_00_01);
    step("snp_rd_i", 1'b0, 4'b0000, 2'b01, 2'b00);
    chk("snp_rd_i_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_00);
    step("snp_wr_m", 1'b0, 4'b0101, 2'b10, 2'b11);
    chk("snp_wr_m_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_01);
    step("snp_wr_e", 1'b0, 4'b0000, 2'b10, 2'b10);
    chk("snp_wr_e_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_00);
    step("snp_inv", 1'b0, 4'b0110, 2'b11, 2'b01);
    chk("snp_inv_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_00);
    step("snp_none", 1'b0, 4'b0011, 2'b00, 2'b10);
    chk("snp_none_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b10_00_00);

    // Clear asserted alongside a write miss from M must win.
    step("clr_wrmiss", 1'b1, 4'b1100, 2'b00, 2'b11);
    chk("clr_wrmiss_abs", {next_state, bus_msg_out, mem_msg_out}, 6'b00_00_00);
    step("post_clear", 1'b0, 4'b1100, 2'b00, 2'b11);

    // Random inputs changing every cycle, occasional clear.
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 15) == 0), 4'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
